// File: rtl/seg7_upd_if.sv
// Update channel for the 7-segment scan controller: a new display value
// (one nibble and one decimal point per digit) offered with ready/valid.
`timescale 1ns/1ps
interface seg7_upd_if #(
  parameter int NDIG = 4
);
  logic              upd_valid;
  logic              upd_ready;
  logic [4*NDIG-1:0] upd_data;
  logic [NDIG-1:0]   upd_dp;

  modport master (output upd_valid, output upd_data, output upd_dp, input upd_ready);
  modport slave  (input upd_valid, input upd_data, input upd_dp, output upd_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of 7-segment digits.
// Each slot opens with a blanking gap, then drives one digit select.
// New values wait in a pending buffer and land in the shadow register
// only at the frame boundary, so a frame never mixes old and new data.
//
//   state   | meaning
//   S_BLANK | cnt 0..BLANK-1, all digit selects inactive
//   S_DRIVE | cnt BLANK..SCAN_DIV-1, select of digit idx active unless suppressed
`timescale 1ns/1ps
module seg7_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK    = 16,
  parameter bit SEL_ACT  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_upd_if.slave       upd,
  input  logic            lz_en,
  output logic [NDIG-1:0] dig_sel,
  output logic [3:0]      seg_nib,
  output logic            seg_dp,
  output logic            frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLEND = CW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [4*NDIG-1:0] shadow_d, pend_d, shd_nxt;
  logic [NDIG-1:0]   shadow_p, pend_p, dp_nxt;
  logic              pend_full;
  logic              supp, supp_nxt;
  logic [NDIG-1:0]   zero_from;
  logic              zero_run;
  logic [NDIG-1:0]   sel_raw;
  logic              wrap, boundary, load, accept;

  assign wrap     = (cnt == CNT_LAST);
  assign boundary = wrap && (idx == IDX_LAST);
  assign load     = boundary && pend_full;
  assign accept   = upd.upd_valid && upd.upd_ready;
  assign idx_nxt  = wrap ? ((idx == IDX_LAST) ? '0 : idx + IW'(1)) : idx;
  assign shd_nxt  = load ? pend_d : shadow_d;
  assign dp_nxt   = load ? pend_p : shadow_p;

  // Suppression decision for the slot about to start, from the shadow it will show.
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run     = zero_run && (shd_nxt[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
    supp_nxt = lz_en && (idx_nxt != '0) && zero_from[idx_nxt] && !dp_nxt[idx_nxt];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BLANK;
    else        state <= state_nxt;
  end

  // Next state and digit select decode.
  always_comb begin
    state_nxt = state;
    sel_raw   = '0;
    case (state)
      S_BLANK: if (cnt == CNT_BLEND) state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (wrap) state_nxt = S_BLANK;
        if (!supp) begin
          for (int i = 0; i < NDIG; i++) sel_raw[i] = (idx == IW'(i));
        end
      end
      default: state_nxt = S_BLANK;
    endcase
    dig_sel = SEL_ACT ? sel_raw : ~sel_raw;
  end

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      idx <= idx_nxt;
    end
  end

  // Pending buffer, shadow register and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_d        <= '0;
      pend_p        <= '0;
      pend_full     <= 1'b0;
      shadow_d      <= '0;
      shadow_p      <= '0;
      upd.upd_ready <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      if (accept) begin
        pend_d    <= upd.upd_data;
        pend_p    <= upd.upd_dp;
        pend_full <= 1'b1;
      end else if (load) begin
        pend_full <= 1'b0;
      end
      shadow_d      <= shd_nxt;
      shadow_p      <= dp_nxt;
      upd.upd_ready <= !(accept || (pend_full && !load));
      frame_tick    <= load;
    end
  end

  // Segment data and suppression latched at each slot start, stable for the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_nib <= 4'd0;
      seg_dp  <= 1'b0;
      supp    <= 1'b0;
    end else if (wrap) begin
      seg_nib <= shd_nxt[{idx_nxt, 2'b00} +: 4];
      seg_dp  <= dp_nxt[idx_nxt];
      supp    <= supp_nxt;
    end
  end

endmodule
